// File: rtl/upload_pkg.sv
// Shared flit control codes and serializer FSM state encodings.
package upload_pkg;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'b00,
    CTRL_HEAD = 2'b01,
    CTRL_BODY = 2'b10,
    CTRL_TAIL = 2'b11
  } ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HEAD = 2'b01,
    ST_BODY = 2'b10
  } state_e;

endpackage

// File: rtl/mcast_dest_sel.sv
// Lowest-set-bit priority encoder: destination mask -> index plus any-set flag.
module mcast_dest_sel #(
  parameter int unsigned NUM_DEST = 4,
  parameter int unsigned DW       = 2
) (
  input  logic [NUM_DEST-1:0] mask,
  output logic [DW-1:0]       idx,
  output logic                any
);

  // Scan from the top down so the lowest set bit is the one that sticks.
  always_comb begin
    idx = '0;
    any = |mask;
    for (int unsigned i = NUM_DEST; i > 0; i--) begin
      if (mask[i-1]) idx = DW'(i - 1);
    end
  end

endmodule

// File: rtl/upload_mcast_serializer.sv
// Serializes a captured upload message into head/addr/data flits, once for
// unicast or once per destination bit for multicast.
module upload_mcast_serializer
  import upload_pkg::*;
#(
  parameter int unsigned FLIT_W   = 16,
  parameter int unsigned MAX_DATA = 8,
  parameter int unsigned NUM_DEST = 4,
  parameter int unsigned DEST_LSB = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           msg_valid,
  output logic                           msg_ready,
  input  logic                           msg_mcast,
  input  logic [NUM_DEST-1:0]            msg_dests,
  input  logic [$clog2(MAX_DATA+1)-1:0]  msg_len,
  input  logic [FLIT_W-1:0]              head_flit,
  input  logic [FLIT_W-1:0]              addrhi,
  input  logic [FLIT_W-1:0]              addrlo,
  input  logic [FLIT_W*MAX_DATA-1:0]     msg_data,
  output logic [FLIT_W-1:0]              flit_out,
  output logic [1:0]                     ctrl_out,
  output logic                           flit_valid,
  input  logic                           flit_ready,
  output logic [1:0]                     fsm_state,
  output logic                           drop_pulse
);

  localparam int unsigned DW = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
  localparam int unsigned LW = $clog2(MAX_DATA + 1);
  localparam int unsigned CW = $clog2(MAX_DATA + 2);

  state_e                    state_q, state_d;
  logic                      mcast_q;
  logic [NUM_DEST-1:0]       mask_q;
  logic [LW-1:0]             len_q;
  logic [FLIT_W-1:0]         head_q, addrhi_q, addrlo_q;
  logic [FLIT_W*MAX_DATA-1:0] data_q;
  logic [CW-1:0]             cnt_q;
  logic                      drop_q;

  logic [NUM_DEST-1:0]       sel_mask, mask_rest;
  logic [DW-1:0]             dest_idx;
  logic                      dest_any;
  logic                      accept, xfer, is_tail;
  logic [FLIT_W-1:0]         body_word;

  // In IDLE the encoder looks at the incoming mask (empty-multicast detect);
  // otherwise it walks the captured mask.
  assign sel_mask = (state_q == ST_IDLE) ? msg_dests : mask_q;

  mcast_dest_sel #(
    .NUM_DEST (NUM_DEST),
    .DW       (DW)
  ) u_dest_sel (
    .mask (sel_mask),
    .idx  (dest_idx),
    .any  (dest_any)
  );

  assign accept    = msg_valid && msg_ready;
  assign xfer      = flit_valid && flit_ready;
  assign is_tail   = (cnt_q == CW'(len_q) + CW'(1));
  assign mask_rest = mask_q & ~(NUM_DEST'(1) << dest_idx);

  always_comb begin
    body_word = '0;
    for (int unsigned k = 0; k < MAX_DATA; k++) begin
      if (cnt_q == CW'(k + 2)) body_word = data_q[k*FLIT_W +: FLIT_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    msg_ready  = 1'b0;
    flit_valid = 1'b0;
    flit_out   = '0;
    ctrl_out   = CTRL_IDLE;
    case (state_q)
      ST_IDLE: begin
        msg_ready = 1'b1;
        if (msg_valid) state_d = (msg_mcast && !dest_any) ? ST_IDLE : ST_HEAD;
      end
      ST_HEAD: begin
        flit_valid = 1'b1;
        ctrl_out   = CTRL_HEAD;
        flit_out   = head_q;
        if (mcast_q) flit_out[DEST_LSB +: DW] = dest_idx;
        if (xfer) state_d = ST_BODY;
      end
      ST_BODY: begin
        flit_valid = 1'b1;
        ctrl_out   = is_tail ? CTRL_TAIL : CTRL_BODY;
        if (cnt_q == '0)               flit_out = addrhi_q;
        else if (cnt_q == CW'(1))      flit_out = addrlo_q;
        else                           flit_out = body_word;
        if (xfer && is_tail) state_d = (mcast_q && |mask_rest) ? ST_HEAD : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mcast_q  <= 1'b0;
      mask_q   <= '0;
      len_q    <= '0;
      head_q   <= '0;
      addrhi_q <= '0;
      addrlo_q <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= accept && msg_mcast && !dest_any;
      if (accept) begin
        mcast_q  <= msg_mcast;
        mask_q   <= msg_dests;
        len_q    <= (msg_len > LW'(MAX_DATA)) ? LW'(MAX_DATA) : msg_len;
        head_q   <= head_flit;
        addrhi_q <= addrhi;
        addrlo_q <= addrlo;
        data_q   <= msg_data;
        cnt_q    <= '0;
      end
      if (xfer) begin
        if (state_q == ST_HEAD) begin
          cnt_q <= '0;
        end else if (is_tail) begin
          cnt_q <= '0;
          if (mcast_q) mask_q <= mask_rest;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign fsm_state  = state_q;
  assign drop_pulse = drop_q;

endmodule

// File: tb/tb_upload_mcast_serializer.sv
// Scoreboard bench: expected flits are queued at message issue and compared
// against every valid output cycle.
module tb_upload_mcast_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         msg_valid, msg_ready, msg_mcast;
  logic [3:0]   msg_dests;
  logic [3:0]   msg_len;
  logic [15:0]  head_flit, addrhi, addrlo;
  logic [127:0] msg_data;
  logic [15:0]  flit_out;
  logic [1:0]   ctrl_out;
  logic         flit_valid, flit_ready;
  logic [1:0]   fsm_state;
  logic         drop_pulse;

  int           errors = 0;
  int           checks = 0;
  int           drops  = 0;
  bit           bp_en  = 1'b0;
  logic [17:0]  exp_q[$];

  upload_mcast_serializer #(
    .FLIT_W   (16),
    .MAX_DATA (8),
    .NUM_DEST (4),
    .DEST_LSB (12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .msg_mcast  (msg_mcast),
    .msg_dests  (msg_dests),
    .msg_len    (msg_len),
    .head_flit  (head_flit),
    .addrhi     (addrhi),
    .addrlo     (addrlo),
    .msg_data   (msg_data),
    .flit_out   (flit_out),
    .ctrl_out   (ctrl_out),
    .flit_valid (flit_valid),
    .flit_ready (flit_ready),
    .fsm_state  (fsm_state),
    .drop_pulse (drop_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Front of queue must be presented whenever valid; pop only on transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (drop_pulse) drops++;
      if (flit_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_flit", 32'(flit_valid), 32'd0);
        end else begin
          check("flit", 32'(flit_out), 32'(exp_q[0][15:0]));
          check("ctrl", 32'(ctrl_out), 32'(exp_q[0][17:16]));
          if (flit_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("ctrl_idle", 32'(ctrl_out), 32'd0);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) flit_ready = ~flit_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  task automatic push_copy(input logic [15:0] hd, input logic [15:0] ahi,
                           input logic [15:0] alo, input logic [127:0] d, input int n);
    exp_q.push_back({2'b01, hd});
    exp_q.push_back({2'b10, ahi});
    exp_q.push_back({(n == 0) ? 2'b11 : 2'b10, alo});
    for (int k = 0; k < n; k++)
      exp_q.push_back({(k == n - 1) ? 2'b11 : 2'b10, d[k*16 +: 16]});
  endtask

  task automatic drive_msg(input bit mc, input logic [3:0] dm, input logic [3:0] ln,
                           input logic [15:0] hd, input logic [15:0] ahi,
                           input logic [15:0] alo, input logic [127:0] d);
    msg_valid = 1'b1;
    msg_mcast = mc;
    msg_dests = dm;
    msg_len   = ln;
    head_flit = hd;
    addrhi    = ahi;
    addrlo    = alo;
    msg_data  = d;
    @(negedge clk);
    check("msg_ready", 32'(msg_ready), 32'd1);
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
  endtask

  task automatic send(input bit mc, input logic [3:0] dm, input logic [3:0] ln,
                      input logic [15:0] hd, input logic [15:0] ahi,
                      input logic [15:0] alo, input logic [127:0] d, input int exp_cyc);
    int n;
    int cyc;
    n = (ln > 4'd8) ? 8 : int'(ln);
    if (!mc) push_copy(hd, ahi, alo, d, n);
    else
      for (int i = 0; i < 4; i++)
        if (dm[i]) push_copy((hd & 16'hCFFF) | (16'(i) << 12), ahi, alo, d, n);
    drive_msg(mc, dm, ln, hd, ahi, alo, d);
    if (mc && dm == 4'd0) begin
      @(negedge clk);
      check("drop_pulse", 32'(drop_pulse), 32'd1);
      check("drop_no_valid", 32'(flit_valid), 32'd0);
      check("drop_ready", 32'(msg_ready), 32'd1);
      check("drop_state", 32'(fsm_state), 32'd0);
      @(negedge clk);
      check("drop_one_cycle", 32'(drop_pulse), 32'd0);
      check("drop_still_idle", 32'(flit_valid), 32'd0);
      @(posedge clk);
      #1;
    end else begin
      @(negedge clk);
      check("first_valid", 32'(flit_valid), 32'd1);
      check("head_state", 32'(fsm_state), 32'd1);
      #1;
      cyc = 1;
      while (exp_q.size() != 0 && cyc < 300) begin
        @(negedge clk);
        #1;
        cyc++;
      end
      check("drained", 32'(exp_q.size()), 32'd0);
      if (exp_cyc > 0) check("cycles", 32'(cyc), 32'(exp_cyc));
      @(posedge clk);
      #1;
      check("idle_after", 32'(fsm_state), 32'd0);
      check("ready_after", 32'(msg_ready), 32'd1);
    end
  endtask

  initial begin
    int seen;
    rst        = 1'b1;
    msg_valid  = 1'b0;
    msg_mcast  = 1'b0;
    msg_dests  = '0;
    msg_len    = '0;
    head_flit  = '0;
    addrhi     = '0;
    addrlo     = '0;
    msg_data   = '0;
    flit_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", 32'(fsm_state), 32'd0);
    check("rst_ready", 32'(msg_ready), 32'd1);
    check("rst_valid", 32'(flit_valid), 32'd0);
    check("rst_ctrl", 32'(ctrl_out), 32'd0);
    check("rst_flit", 32'(flit_out), 32'd0);
    check("rst_drop", 32'(drop_pulse), 32'd0);
    @(posedge clk);
    #1;

    // Unicast: dest field in head untouched, mask ignored.
    send(1'b0, 4'b0110, 4'd2, 16'hB5A5, 16'h1111, 16'h2222,
         128'h8888_7777_6666_5555_4444_3333_AAAA_9999, 5);
    // Multicast 1010: heads 1000 then 3000, copies back to back.
    send(1'b1, 4'b1010, 4'd2, 16'h0000, 16'hA1A1, 16'hA2A2,
         128'h0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_0_BEEF_CAFE, 10);

    bp_en = 1'b1;
    send(1'b0, 4'b0000, 4'd1, 16'h4321, 16'h5555, 16'h6666,
         128'h0000_0000_0000_0000_0000_0000_0000_7777, -1);
    send(1'b1, 4'b0101, 4'd0, 16'hFFFF, 16'h0102, 16'h0304, 128'd0, -1);
    bp_en = 1'b0;
    @(posedge clk);
    #2;
    flit_ready = 1'b1;

    send(1'b1, 4'b0000, 4'd3, 16'h1234, 16'h0001, 16'h0002, 128'd0, -1);
    send(1'b0, 4'b1111, 4'd0, 16'h7777, 16'hABCD, 16'hDCBA, 128'd0, 3);

    // Reset in the body of the first copy of a 4-way multicast.
    push_copy(16'h0ACE & 16'hCFFF, 16'h1357, 16'h2468,
              128'h0000_0000_0000_0000_0000_0303_0202_0101, 3);
    drive_msg(1'b1, 4'b1111, 4'd3, 16'h0ACE, 16'h1357, 16'h2468,
              128'h0000_0000_0000_0000_0000_0303_0202_0101);
    repeat (3) @(negedge clk);
    #1;
    check("in_body", 32'(fsm_state), 32'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_valid", 32'(flit_valid), 32'd0);
    check("rst_mid_state", 32'(fsm_state), 32'd0);
    check("rst_mid_ready", 32'(msg_ready), 32'd1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (flit_valid) seen++;
    end
    check("no_resume", 32'(seen), 32'd0);
    @(posedge clk);
    #1;

    // len=15 clamps to 8 data flits.
    send(1'b0, 4'b0000, 4'd15, 16'h0F0F, 16'hC001, 16'hC002,
         128'hD008_D007_D006_D005_D004_D003_D002_D001, 11);

    check("drop_count", 32'(drops), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
